tail_light_decoder: RTL and testbench
=====================================

TAIL_LIGHT_DECODER -- requirements
Module: tail_light_decoder

Interface
REQ-001 SHALL have parameter ERR_W, default 8: width of the error counter.
REQ-002 SHALL have port Clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports La, Lb, Lc, input, 1 each: left lamps, inner to outer.
REQ-005 SHALL have ports Ra, Rb, Rc, input, 1 each: right lamps, inner to outer.
REQ-006 SHALL have port Mode, output, 2: decoded mode, with 00 IDLE, 01 LEFT, 10 RIGHT, 11 HAZARD.
REQ-007 SHALL have port Phase, output, 2: sequence step. L1/R1=1, L2/R2=2, L3/R3=3, hazard-on=1, OFF=0.
REQ-008 SHALL have port Err, output, 1: one-cycle pulse on a protocol violation.
REQ-009 SHALL have port ErrCnt, output, ERR_W: count of protocol violations, saturating.

Function
REQ-010 SHALL sample all six lamps on every rising Clk and classify the sample as exactly one pattern:
- OFF: all six low.
- L1: La only. L2: La+Lb. L3: La+Lb+Lc.
- R1: Ra only. R2: Ra+Rb. R3: Ra+Rb+Rc.
- ALL: all six high.
- BAD: anything else.
REQ-011 SHALL track a state in {OFF, L1, L2, L3, R1, R2, R3, ALL, SYNC}.
REQ-012 SHALL accept only these successors (anything else is a violation):
- From OFF: OFF, L1, R1, ALL.
- From L1: L2, OFF, ALL. From L2: L3, OFF, ALL. From L3: OFF, ALL.
- From R1, R2, R3: mirror of the L1, L2, L3 rows.
- From ALL: OFF.
REQ-013 SHALL register all outputs, so every output reflects the sample taken one Clk earlier (latency 1).
REQ-014 SHALL set Mode as follows:
- Pattern L1..L3: LEFT.
- Pattern R1..R3: RIGHT.
- Pattern ALL: HAZARD.
- First OFF after a non-OFF state: hold the previous Mode.
- Second consecutive OFF: IDLE.
REQ-015 SHALL, on a violation (illegal successor, or BAD from any state except SYNC):
- pulse Err for exactly one cycle;
- increment ErrCnt, saturating at all-ones;
- enter SYNC with Mode=IDLE and Phase=0.
REQ-016 SHALL, in SYNC:
- accept any recognized pattern without Err and take that pattern's state;
- stay in SYNC on BAD without a further Err or ErrCnt increment.
REQ-017 SHALL keep ErrCnt unchanged when it is already saturated and a violation occurs; Err still pulses.
REQ-018 SHALL use no timeout beyond the two-OFF rule; a steady OFF input holds IDLE indefinitely.

Reset
REQ-019 SHALL, when Reset=1 at a rising Clk, force:
- state OFF, with the consecutive-OFF count at 2;
- Mode=00, Phase=00, Err=0, ErrCnt=0.
REQ-020 SHALL give Reset priority over every simultaneous event, including a violation in the same cycle.
REQ-021 SHALL, after Reset is released, treat the next sample as a successor of OFF.

Structure
REQ-022 SHALL place the pattern encodings, state encodings and Mode constants in the shared package tail_light_pkg, so the lamp controller and its bench can reuse them.
REQ-023 SHALL implement the BAD/legal pattern classification as the combinational sub-module lamp_pattern_classify; transition and counter logic stays in tail_light_decoder.

Verification
REQ-024 SHALL cover the left sequence: OFF,L1,L2,L3,OFF,L1 on consecutive cycles -> Mode=01 throughout from cycle 2; Phase 1,2,3,0,1; Err never asserted.
REQ-025 SHALL cover hazard: OFF,ALL,OFF,ALL,OFF,OFF -> Mode=11 until the second consecutive OFF, then 00; Phase 1,0,1,0,0.
REQ-026 SHALL cover a skipped step: OFF,R1,R3 -> Err=1 for one cycle after R3 sampled; ErrCnt=1; Mode=00. A following R1 -> Mode=10, no Err.
REQ-027 SHALL cover BAD flooding: La+Ra held for 5 cycles, then OFF -> exactly one Err pulse; ErrCnt=1; state leaves SYNC on OFF.
REQ-028 SHALL cover saturation: ERR_W=2 with 5 violations, each separated by OFF -> ErrCnt ends at 3; Err pulses 5 times.
REQ-029 SHALL cover reset mid-sequence: Reset asserted while L2 is sampled with a violation pending -> next cycle Mode=00, Phase=0, Err=0, ErrCnt=0; L1 after release accepted.

Source files
------------

// File: rtl/tail_light_pkg.sv
// Shared encodings for the tail-light decoder: lamp patterns, tracker states
// and Mode values, plus small lookups from a pattern to its state/mode/phase.
package tail_light_pkg;

  typedef enum logic [3:0] {
    PAT_OFF, PAT_L1, PAT_L2, PAT_L3, PAT_R1, PAT_R2, PAT_R3, PAT_ALL, PAT_BAD
  } pattern_e;

  typedef enum logic [3:0] {
    ST_OFF, ST_L1, ST_L2, ST_L3, ST_R1, ST_R2, ST_R3, ST_ALL, ST_SYNC
  } state_e;

  localparam logic [1:0] MODE_IDLE   = 2'b00;
  localparam logic [1:0] MODE_LEFT   = 2'b01;
  localparam logic [1:0] MODE_RIGHT  = 2'b10;
  localparam logic [1:0] MODE_HAZARD = 2'b11;

  function automatic state_e pat_to_state(input pattern_e p);
    case (p)
      PAT_L1:  return ST_L1;
      PAT_L2:  return ST_L2;
      PAT_L3:  return ST_L3;
      PAT_R1:  return ST_R1;
      PAT_R2:  return ST_R2;
      PAT_R3:  return ST_R3;
      PAT_ALL: return ST_ALL;
      default: return ST_OFF;
    endcase
  endfunction

  function automatic logic [1:0] pat_mode(input pattern_e p);
    case (p)
      PAT_L1, PAT_L2, PAT_L3: return MODE_LEFT;
      PAT_R1, PAT_R2, PAT_R3: return MODE_RIGHT;
      PAT_ALL:                return MODE_HAZARD;
      default:                return MODE_IDLE;
    endcase
  endfunction

  function automatic logic [1:0] pat_phase(input pattern_e p);
    case (p)
      PAT_L1, PAT_R1, PAT_ALL: return 2'd1;
      PAT_L2, PAT_R2:          return 2'd2;
      PAT_L3, PAT_R3:          return 2'd3;
      default:                 return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/lamp_pattern_classify.sv
// Combinational classifier: maps the six lamp levels {La,Lb,Lc,Ra,Rb,Rc}
// onto exactly one recognised pattern, or PAT_BAD.
module lamp_pattern_classify
  import tail_light_pkg::*;
(
  input  logic [5:0] lamps_i,
  output pattern_e   pattern_o
);

  always_comb begin
    pattern_o = PAT_BAD;
    case (lamps_i)
      6'b000000: pattern_o = PAT_OFF;
      6'b100000: pattern_o = PAT_L1;
      6'b110000: pattern_o = PAT_L2;
      6'b111000: pattern_o = PAT_L3;
      6'b000100: pattern_o = PAT_R1;
      6'b000110: pattern_o = PAT_R2;
      6'b000111: pattern_o = PAT_R3;
      6'b111111: pattern_o = PAT_ALL;
      default:   pattern_o = PAT_BAD;
    endcase
  end

endmodule

// File: rtl/tail_light_decoder.sv
// Tail-light sequence tracker: checks each lamp sample against the legal
// successors of the previous one and reports mode, phase and violations.
module tail_light_decoder
  import tail_light_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             La,
  input  logic             Lb,
  input  logic             Lc,
  input  logic             Ra,
  input  logic             Rb,
  input  logic             Rc,
  output logic [1:0]       Mode,
  output logic [1:0]       Phase,
  output logic             Err,
  output logic [ERR_W-1:0] ErrCnt
);

  pattern_e         pattern;
  logic             legal;
  state_e           state_q, state_d;
  logic [1:0]       off_cnt_q, off_cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [1:0]       phase_q, phase_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  lamp_pattern_classify u_classify (
    .lamps_i   ({La, Lb, Lc, Ra, Rb, Rc}),
    .pattern_o (pattern)
  );

  always_comb begin
    legal = 1'b0;
    case (state_q)
      ST_OFF:  legal = pattern inside {PAT_OFF, PAT_L1, PAT_R1, PAT_ALL};
      ST_L1:   legal = pattern inside {PAT_L2, PAT_OFF, PAT_ALL};
      ST_L2:   legal = pattern inside {PAT_L3, PAT_OFF, PAT_ALL};
      ST_L3:   legal = pattern inside {PAT_OFF, PAT_ALL};
      ST_R1:   legal = pattern inside {PAT_R2, PAT_OFF, PAT_ALL};
      ST_R2:   legal = pattern inside {PAT_R3, PAT_OFF, PAT_ALL};
      ST_R3:   legal = pattern inside {PAT_OFF, PAT_ALL};
      ST_ALL:  legal = (pattern == PAT_OFF);
      default: legal = (pattern != PAT_BAD);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    off_cnt_d = off_cnt_q;
    mode_d    = mode_q;
    phase_d   = phase_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    if (state_q == ST_SYNC && pattern == PAT_BAD) begin
      mode_d  = MODE_IDLE;
      phase_d = 2'd0;
    end else if (!legal) begin
      err_d     = 1'b1;
      state_d   = ST_SYNC;
      off_cnt_d = 2'd0;
      mode_d    = MODE_IDLE;
      phase_d   = 2'd0;
      if (err_cnt_q != {ERR_W{1'b1}})
        err_cnt_d = err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
    end else begin
      state_d = pat_to_state(pattern);
      phase_d = pat_phase(pattern);
      if (pattern == PAT_OFF) begin
        // First OFF keeps the blinking mode; only a second in a row goes idle.
        off_cnt_d = (off_cnt_q == 2'd2) ? 2'd2 : off_cnt_q + 2'd1;
        mode_d    = (off_cnt_d == 2'd2) ? MODE_IDLE : mode_q;
      end else begin
        off_cnt_d = 2'd0;
        mode_d    = pat_mode(pattern);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_OFF;
      off_cnt_q <= 2'd2;
      mode_q    <= MODE_IDLE;
      phase_q   <= 2'd0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      off_cnt_q <= off_cnt_d;
      mode_q    <= mode_d;
      phase_q   <= phase_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign Mode   = mode_q;
  assign Phase  = phase_q;
  assign Err    = err_q;
  assign ErrCnt = err_cnt_q;

endmodule

// File: tb/tb_tail_light_decoder.sv
// Scoreboard bench for tail_light_decoder: a reference model predicts each
// registered output set when a sample is driven; it is compared one cycle on.
module tb_tail_light_decoder;

  localparam int ERR_W = 2;
  localparam int P_BAD = 8;
  localparam int P_SYNC = 9;

  localparam logic [5:0] V_OFF = 6'b000000;
  localparam logic [5:0] V_L1  = 6'b100000;
  localparam logic [5:0] V_L2  = 6'b110000;
  localparam logic [5:0] V_L3  = 6'b111000;
  localparam logic [5:0] V_R1  = 6'b000100;
  localparam logic [5:0] V_R2  = 6'b000110;
  localparam logic [5:0] V_R3  = 6'b000111;
  localparam logic [5:0] V_ALL = 6'b111111;
  localparam logic [5:0] V_LR  = 6'b100100;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic La = 1'b0, Lb = 1'b0, Lc = 1'b0, Ra = 1'b0, Rb = 1'b0, Rc = 1'b0;
  logic [1:0]       Mode, Phase;
  logic             Err;
  logic [ERR_W-1:0] ErrCnt;

  tail_light_decoder #(.ERR_W(ERR_W)) dut (
    .Clk(Clk), .Reset(Reset),
    .La(La), .Lb(Lb), .Lc(Lc), .Ra(Ra), .Rb(Rb), .Rc(Rc),
    .Mode(Mode), .Phase(Phase), .Err(Err), .ErrCnt(ErrCnt)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [1:0]       mode;
    logic [1:0]       phase;
    logic             err;
    logic [ERR_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int n_txn = 0;
  int err_seen = 0;

  int               m_st = 0;
  logic [1:0]       m_mode = 2'b00;
  logic [1:0]       m_phase = 2'b00;
  logic             m_err = 1'b0;
  logic [ERR_W-1:0] m_cnt = '0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int classify(input logic [5:0] v);
    case (v)
      V_OFF:   return 0;
      V_L1:    return 1;
      V_L2:    return 2;
      V_L3:    return 3;
      V_R1:    return 4;
      V_R2:    return 5;
      V_R3:    return 6;
      V_ALL:   return 7;
      default: return P_BAD;
    endcase
  endfunction

  // Steps advance by one within a side; only the first step may follow OFF.
  function automatic bit legal_next(input int prev, input int pat);
    if (pat == P_BAD) return prev == P_SYNC;
    if (prev == P_SYNC || pat == 0) return 1'b1;
    if (pat == 7) return prev != 7;
    if (pat == 1 || pat == 4) return prev == 0;
    if (pat == 2 || pat == 3) return prev == pat - 1;
    return prev == pat - 1;
  endfunction

  task automatic model(input logic rst, input logic [5:0] v);
    int p;
    p = classify(v);
    m_err = 1'b0;
    if (rst) begin
      m_st = 0; m_mode = 2'b00; m_phase = 2'b00; m_cnt = '0;
    end else if (m_st == P_SYNC && p == P_BAD) begin
      m_mode = 2'b00; m_phase = 2'b00;
    end else if (!legal_next(m_st, p)) begin
      m_err = 1'b1;
      if (m_cnt != {ERR_W{1'b1}}) m_cnt = m_cnt + 1'b1;
      m_st = P_SYNC; m_mode = 2'b00; m_phase = 2'b00;
    end else begin
      if (p == 0) begin
        if (m_st == 0) m_mode = 2'b00;
        m_phase = 2'd0;
      end else if (p <= 3) begin
        m_mode = 2'b01; m_phase = 2'(p);
      end else if (p <= 6) begin
        m_mode = 2'b10; m_phase = 2'(p - 3);
      end else begin
        m_mode = 2'b11; m_phase = 2'd1;
      end
      m_st = p;
    end
  endtask

  task automatic step(input logic rst, input logic [5:0] v, input string tag);
    exp_t e;
    @(negedge Clk);
    Reset = rst;
    {La, Lb, Lc, Ra, Rb, Rc} = v;
    model(rst, v);
    e.mode = m_mode; e.phase = m_phase; e.err = m_err; e.cnt = m_cnt;
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
    e = exp_q.pop_front();
    n_txn++;
    if (Err === 1'b1) err_seen++;
    $display("txn %0d %s rst=%b lamps=%b mode=%b phase=%0d err=%b cnt=%0d",
             n_txn, tag, rst, v, Mode, Phase, Err, ErrCnt);
    check_eq({tag, ".mode"},  int'(Mode),   int'(e.mode));
    check_eq({tag, ".phase"}, int'(Phase),  int'(e.phase));
    check_eq({tag, ".err"},   int'(Err),    int'(e.err));
    check_eq({tag, ".cnt"},   int'(ErrCnt), int'(e.cnt));
  endtask

  logic [5:0] vecs [9];

  initial begin
    vecs[0] = V_OFF; vecs[1] = V_L1; vecs[2] = V_L2; vecs[3] = V_L3;
    vecs[4] = V_R1;  vecs[5] = V_R2; vecs[6] = V_R3; vecs[7] = V_ALL;
    vecs[8] = V_LR;

    step(1'b1, V_OFF, "reset");
    check_eq("reset.mode_zero", int'(Mode), 0);

    // left sequence
    step(1'b0, V_OFF, "left.off");
    step(1'b0, V_L1,  "left.l1");
    step(1'b0, V_L2,  "left.l2");
    step(1'b0, V_L3,  "left.l3");
    step(1'b0, V_OFF, "left.off1");
    check_eq("left.hold_mode", int'(Mode), 1);
    step(1'b0, V_L1,  "left.l1b");

    // hazard
    step(1'b0, V_OFF, "haz.off");
    step(1'b0, V_OFF, "haz.off");
    step(1'b0, V_ALL, "haz.all");
    step(1'b0, V_OFF, "haz.off1");
    step(1'b0, V_ALL, "haz.all");
    step(1'b0, V_OFF, "haz.off1");
    check_eq("haz.hold_mode", int'(Mode), 3);
    step(1'b0, V_OFF, "haz.off2");
    check_eq("haz.idle_mode", int'(Mode), 0);

    // skipped step
    step(1'b0, V_R1,  "skip.r1");
    step(1'b0, V_R3,  "skip.r3");
    check_eq("skip.err_pulse", int'(Err), 1);
    step(1'b0, V_R1,  "skip.r1b");
    check_eq("skip.recover_mode", int'(Mode), 2);

    // BAD flooding
    step(1'b1, V_OFF, "flood.rst");
    err_seen = 0;
    for (int i = 0; i < 5; i++) step(1'b0, V_LR, "flood.bad");
    step(1'b0, V_OFF, "flood.off");
    step(1'b0, V_L1,  "flood.l1");
    check_eq("flood.err_pulses", err_seen, 1);

    // saturation with a 2-bit counter
    step(1'b1, V_OFF, "sat.rst");
    err_seen = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, V_L2,  "sat.viol");
      step(1'b0, V_OFF, "sat.off");
    end
    check_eq("sat.err_pulses", err_seen, 5);
    check_eq("sat.final_cnt", int'(ErrCnt), 3);

    // reset while a violation is pending
    step(1'b0, V_L3, "rst.viol");
    step(1'b1, V_L2, "rst.l2");
    step(1'b0, V_L1, "rst.l1");

    // random patterns with occasional reset
    for (int i = 0; i < 200; i++) begin
      logic [5:0] v;
      v = vecs[$urandom_range(0, 8)];
      if ($urandom_range(0, 9) == 0) v = 6'($urandom_range(0, 63));
      step(($urandom_range(0, 39) == 0), v, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
